// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate divider, x/y counters, H/V porch FSMs and registered syncs.
// Define VGA_TIMING_FRAME_CNT_EN to build the completed-frame counter; otherwise frame_count is tied to 0.
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int CLK_DIV   = 2,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int X_W      = $clog2(H_TOTAL),
  localparam int Y_W      = $clog2(V_TOTAL)
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_i,
  input  logic           enable,
  output logic           pix_stb,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           active,
  output logic           hsync,
  output logic           vsync,
  output logic           line_start,
  output logic           frame_start,
  output logic [15:0]    frame_count
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [X_W-1:0] X_ACT   = X_W'(H_ACTIVE);
  localparam logic [X_W-1:0] X_A_END = X_W'(H_ACTIVE - 1);
  localparam logic [X_W-1:0] X_F_END = X_W'(H_ACTIVE + H_FP - 1);
  localparam logic [X_W-1:0] X_S_END = X_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [X_W-1:0] X_LAST  = X_W'(H_TOTAL - 1);
  localparam logic [Y_W-1:0] Y_ACT   = Y_W'(V_ACTIVE);
  localparam logic [Y_W-1:0] Y_A_END = Y_W'(V_ACTIVE - 1);
  localparam logic [Y_W-1:0] Y_F_END = Y_W'(V_ACTIVE + V_FP - 1);
  localparam logic [Y_W-1:0] Y_S_END = Y_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [Y_W-1:0] Y_LAST  = Y_W'(V_TOTAL - 1);
  localparam logic HS_ON = (HSYNC_POL != 0) ? 1'b1 : 1'b0;
  localparam logic VS_ON = (VSYNC_POL != 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {H_ST_ACT, H_ST_FRONT, H_ST_SYNC, H_ST_BACK} h_state_t;
  typedef enum logic [1:0] {V_ST_ACT, V_ST_FRONT, V_ST_SYNC, V_ST_BACK} v_state_t;

  logic [DIV_W-1:0] div_q, div_d;
  logic             running_q, running_d;
  logic [X_W-1:0]   x_q, x_d;
  logic [Y_W-1:0]   y_q, y_d;
  h_state_t         hst_q, hst_d;
  v_state_t         vst_q, vst_d;
  logic             pix_stb_q, pix_stb_d;
  logic             active_q, active_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             line_start_q, line_start_d;
  logic             frame_start_q, frame_start_d;
  logic             tick;
  logic             line_wrap;

  assign tick      = (div_q == DIV_LAST);
  assign line_wrap = enable && tick && running_q && (x_q == X_LAST);

  always_comb begin
    div_d         = div_q;
    running_d     = running_q;
    x_d           = x_q;
    y_d           = y_q;
    hst_d         = hst_q;
    vst_d         = vst_q;
    active_d      = active_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    pix_stb_d     = 1'b0;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (!enable) begin
      div_d     = '0;
      running_d = 1'b0;
      x_d       = '0;
      y_d       = '0;
      hst_d     = H_ST_ACT;
      vst_d     = V_ST_ACT;
      active_d  = 1'b0;
      hsync_d   = ~HS_ON;
      vsync_d   = ~VS_ON;
    end else begin
      div_d = tick ? '0 : div_q + DIV_W'(1);
      if (tick) begin
        pix_stb_d = 1'b1;
        // The first tick after enabling only presents (0,0); counters start moving on the next one.
        if (!running_q) begin
          running_d = 1'b1;
        end else begin
          if (x_q == X_LAST) begin
            x_d = '0;
            y_d = (y_q == Y_LAST) ? '0 : y_q + Y_W'(1);
            unique case (vst_q)
              V_ST_ACT:   if (y_q == Y_A_END) vst_d = V_ST_FRONT;
              V_ST_FRONT: if (y_q == Y_F_END) vst_d = V_ST_SYNC;
              V_ST_SYNC:  if (y_q == Y_S_END) vst_d = V_ST_BACK;
              V_ST_BACK:  if (y_q == Y_LAST)  vst_d = V_ST_ACT;
              default:    vst_d = V_ST_ACT;
            endcase
          end else begin
            x_d = x_q + X_W'(1);
          end
          unique case (hst_q)
            H_ST_ACT:   if (x_q == X_A_END) hst_d = H_ST_FRONT;
            H_ST_FRONT: if (x_q == X_F_END) hst_d = H_ST_SYNC;
            H_ST_SYNC:  if (x_q == X_S_END) hst_d = H_ST_BACK;
            H_ST_BACK:  if (x_q == X_LAST)  hst_d = H_ST_ACT;
            default:    hst_d = H_ST_ACT;
          endcase
        end
        active_d      = (x_d < X_ACT) && (y_d < Y_ACT);
        hsync_d       = (hst_d == H_ST_SYNC) ? HS_ON : ~HS_ON;
        vsync_d       = (vst_d == V_ST_SYNC) ? VS_ON : ~VS_ON;
        line_start_d  = (x_d == '0);
        frame_start_d = (x_d == '0) && (y_d == '0);
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      div_q         <= '0;
      running_q     <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      hst_q         <= H_ST_ACT;
      vst_q         <= V_ST_ACT;
      pix_stb_q     <= 1'b0;
      active_q      <= 1'b0;
      hsync_q       <= ~HS_ON;
      vsync_q       <= ~VS_ON;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      running_q     <= running_d;
      x_q           <= x_d;
      y_q           <= y_d;
      hst_q         <= hst_d;
      vst_q         <= vst_d;
      pix_stb_q     <= pix_stb_d;
      active_q      <= active_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_count_q, frame_count_d;

  always_comb begin
    frame_count_d = frame_count_q;
    if (line_wrap && (y_q == Y_LAST)) frame_count_d = frame_count_q + 16'd1;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) frame_count_q <= '0;
    else          frame_count_q <= frame_count_d;
  end

  assign frame_count = frame_count_q;
`else
  logic unused_line_wrap;
  assign unused_line_wrap = line_wrap;
  assign frame_count      = '0;
`endif

  assign pix_stb     = pix_stb_q;
  assign x           = x_q;
  assign y           = y_q;
  assign active      = active_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: small 14x8 raster at CLK_DIV=2 plus a CLK_DIV=1 instance.
module tb_vga_timing_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en0, en1;
  logic pix0, act0, hs0, vs0, ls0, fs0;
  logic [3:0] x0;
  logic [2:0] y0;
  logic [15:0] fc0;
  logic pix1, act1, hs1, vs1, ls1, fs1;
  logic [3:0] x1;
  logic [2:0] y1;
  logic [15:0] fc1;

`ifdef VGA_TIMING_FRAME_CNT_EN
  localparam int EXP_FC = 1;
`else
  localparam int EXP_FC = 0;
`endif

  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
                   .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
                   .CLK_DIV(2), .HSYNC_POL(0), .VSYNC_POL(0)) u0 (
    .wb_clk_i(clk), .wb_rst_i(rst), .enable(en0), .pix_stb(pix0), .x(x0), .y(y0),
    .active(act0), .hsync(hs0), .vsync(vs0), .line_start(ls0), .frame_start(fs0),
    .frame_count(fc0));

  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
                   .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
                   .CLK_DIV(1), .HSYNC_POL(0), .VSYNC_POL(0)) u1 (
    .wb_clk_i(clk), .wb_rst_i(rst), .enable(en1), .pix_stb(pix1), .x(x1), .y(y1),
    .active(act1), .hsync(hs1), .vsync(vs1), .line_start(ls1), .frame_start(fs1),
    .frame_count(fc1));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic check_out0(input string tag, input logic stb, input int ex, input int ey,
                            input logic a, input logic h, input logic v,
                            input logic l, input logic f);
    chk({tag, ".pix_stb"}, 32'(pix0), 32'(stb));
    chk({tag, ".x"}, 32'(x0), ex);
    chk({tag, ".y"}, 32'(y0), ey);
    chk({tag, ".active"}, 32'(act0), 32'(a));
    chk({tag, ".hsync"}, 32'(hs0), 32'(h));
    chk({tag, ".vsync"}, 32'(vs0), 32'(v));
    chk({tag, ".line_start"}, 32'(ls0), 32'(l));
    chk({tag, ".frame_start"}, 32'(fs0), 32'(f));
  endtask

  // One pixel period of u0: a quiet edge, then the strobe edge presenting (ex,ey).
  task automatic pixel0(input string tag, input int ex, input int ey);
    @(posedge clk); #1;
    chk({tag, ".gap"}, 32'(pix0), 0);
    @(posedge clk); #1;
    check_out0(tag, 1'b1, ex, ey, (ex < 8) && (ey < 4), !(ex >= 10 && ex <= 12),
               !(ey >= 5 && ey <= 6), ex == 0, (ex == 0) && (ey == 0));
  endtask

  typedef struct {
    logic rst; logic en;
    logic stb; int x; int y; logic act; logic hs; logic vs; logic ls; logic fs;
  } vec_t;
  vec_t vt[9];

  initial begin
    rst = 1'b1; en0 = 1'b0; en1 = 1'b0;
    vt[0] = '{1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[1] = '{1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[2] = '{1'b0, 1'b1, 1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vt[3] = '{1'b0, 1'b1, 1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[4] = '{1'b0, 1'b1, 1'b1, 1, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[5] = '{1'b0, 1'b1, 1'b0, 1, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[6] = '{1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[7] = '{1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[8] = '{1'b0, 1'b1, 1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    for (int i = 0; i < 9; i++) begin
      rst = vt[i].rst; en0 = vt[i].en;
      @(posedge clk); #1;
      check_out0($sformatf("vec%0d", i), vt[i].stb, vt[i].x, vt[i].y, vt[i].act,
                 vt[i].hs, vt[i].vs, vt[i].ls, vt[i].fs);
      if (i == 0) chk("reset.frame_count", 32'(fc0), 0);
    end

    // Full frame from (0,0) back to (0,0), then on to (5,2).
    for (int p = 1; p <= 112 + 33; p++) begin
      pixel0($sformatf("px%0d", p), p % 14, (p / 14) % 8);
      if (p == 111) chk("frame.fc_before", 32'(fc0), 0);
      if (p == 112) chk("frame.fc_after", 32'(fc0), EXP_FC);
    end

    en0 = 1'b0;
    @(posedge clk); #1;
    check_out0("drop", 1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("drop.fc_hold", 32'(fc0), EXP_FC);
    en0 = 1'b1;
    @(posedge clk); #1;
    chk("reen.edge1", 32'(pix0), 0);
    @(posedge clk); #1;
    check_out0("reen", 1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);

    for (int p = 1; p <= 20; p++) pixel0($sformatf("run%0d", p), p % 14, p / 14);

    rst = 1'b1;
    @(posedge clk); #1;
    check_out0("rst", 1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("rst.frame_count", 32'(fc0), 0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("rsthold%0d.pulses", k), {29'd0, pix0, ls0, fs0}, 0);
    end
    rst = 1'b0;

    en1 = 1'b1;
    @(posedge clk); #1;
    chk("div1.first_stb", 32'(pix1), 1);
    chk("div1.first_fs", 32'(fs1), 1);
    chk("div1.first_x", 32'(x1), 0);
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk); #1;
      chk($sformatf("div1.stb%0d", k), 32'(pix1), 1);
      chk($sformatf("div1.x%0d", k), 32'(x1), k % 14);
      chk($sformatf("div1.y%0d", k), 32'(y1), k / 14);
    end
    chk("div1.line_start", 32'(ls1), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
